// File: rtl/output_port_scheduler.sv
// Round-robin output-port scheduler: arbitrates requesters, issues a control token, then
// holds the grant for len+1 flits. Define SCHED_CORE_PRIO_EN to give the core strict priority.
module output_port_scheduler #(
    parameter int unsigned NREQ = 5,
    parameter int unsigned LENW = 3
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LENW-1:0] len,
    output logic                 ctrl_valid,
    output logic [2:0]           ctrl_code,
    input  logic                 ctrl_ready,
    input  logic                 flit_done,
    output logic [NREQ-1:0]      grant,
    output logic                 busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     win_q, win_d;
    logic [LENW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [2:0]        code_q, code_d;

    logic              found;
    logic [PW-1:0]     win_sel;
    logic [PW-1:0]     cur;

    // Search upward from ptr with wrap; first requesting index wins.
    always_comb begin
        found   = 1'b0;
        win_sel = '0;
        cur     = ptr_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[cur]) begin
                found   = 1'b1;
                win_sel = cur;
            end
            cur = (cur == PW'(NREQ - 1)) ? '0 : cur + 1'b1;
        end
`ifdef SCHED_CORE_PRIO_EN
        if (req[NREQ-1]) begin
            found   = 1'b1;
            win_sel = PW'(NREQ - 1);
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        code_d  = code_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StIssue;
                    win_d   = win_sel;
                    grant_d = NREQ'(1) << win_sel;
                    code_d  = 3'(win_sel);
                    cnt_d   = len[32'(win_sel)*LENW +: LENW];
                end
            end
            StIssue: begin
                if (ctrl_ready) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (flit_done) begin
                    if (cnt_q == '0) begin
                        state_d = StIdle;
                        grant_d = '0;
                        code_d  = '0;
                        ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            code_q  <= code_d;
        end
    end

    assign ctrl_valid = (state_q == StIssue);
    assign busy       = (state_q != StIdle);
    assign grant      = grant_q;
    assign ctrl_code  = code_q;

endmodule

// File: tb/tb_output_port_scheduler.sv
// Directed bench for output_port_scheduler: table of packets with hand-computed winners,
// plus sequences for back-pressure, reset abandonment and late req/len changes.
module tb_output_port_scheduler;

    logic        CLK;
    logic        RESET;
    logic [4:0]  req;
    logic [14:0] len;
    logic        ctrl_valid;
    logic [2:0]  ctrl_code;
    logic        ctrl_ready;
    logic        flit_done;
    logic [4:0]  grant;
    logic        busy;

    int errors = 0;
    int checks = 0;

    output_port_scheduler #(.NREQ(5), .LENW(3)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .req        (req),
        .len        (len),
        .ctrl_valid (ctrl_valid),
        .ctrl_code  (ctrl_code),
        .ctrl_ready (ctrl_ready),
        .flit_done  (flit_done),
        .grant      (grant),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0] req;
        logic [2:0] lv;
        logic [2:0] code;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle(input string name);
        chk({name, ".valid"}, 32'(ctrl_valid), 32'd0);
        chk({name, ".code"},  32'(ctrl_code),  32'd0);
        chk({name, ".grant"}, 32'(grant),      32'd0);
        chk({name, ".busy"},  32'(busy),       32'd0);
    endtask

    task automatic chk_issue(input string name, input logic [2:0] code);
        chk({name, ".valid"}, 32'(ctrl_valid), 32'd1);
        chk({name, ".code"},  32'(ctrl_code),  32'(code));
        chk({name, ".grant"}, 32'(grant),      32'(5'b00001 << code));
        chk({name, ".busy"},  32'(busy),       32'd1);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        // ptr after each packet noted; winners computed by hand from previous ptr.
        tbl[0] = '{req: 5'b00100, lv: 3'd0, code: 3'd2}; // ptr 0 -> 3
        tbl[1] = '{req: 5'b10010, lv: 3'd1, code: 3'd4}; // ptr 3 -> 0
        tbl[2] = '{req: 5'b00110, lv: 3'd0, code: 3'd1}; // ptr 0 -> 2
        tbl[3] = '{req: 5'b00011, lv: 3'd2, code: 3'd0}; // ptr 2 -> 1
        tbl[4] = '{req: 5'b01001, lv: 3'd0, code: 3'd3}; // ptr 1 -> 4
        tbl[5] = '{req: 5'b00110, lv: 3'd5, code: 3'd1}; // ptr 4 -> 2
        tbl[6] = '{req: 5'b00101, lv: 3'd0, code: 3'd2}; // ptr 2 -> 3
        tbl[7] = '{req: 5'b00011, lv: 3'd0, code: 3'd0}; // ptr 3 -> 1

        req = '0; len = '0; ctrl_ready = 1'b0; flit_done = 1'b0;
        RESET = 1'b1;
        #2;
        chk_idle("reset");
        tick();
        RESET = 1'b0;
        tick();
        chk_idle("post_reset");

        for (int v = 0; v < 8; v++) begin
            req = tbl[v].req;
            len = {5{tbl[v].lv}};
            tick();
            req = '0;
            chk_issue($sformatf("vec%0d.issue", v), tbl[v].code);
            ctrl_ready = 1'b1;
            tick();
            ctrl_ready = 1'b0;
            chk($sformatf("vec%0d.hold_valid", v), 32'(ctrl_valid), 32'd0);
            chk($sformatf("vec%0d.hold_code", v), 32'(ctrl_code), 32'(tbl[v].code));
            for (int k = 0; k <= int'(tbl[v].lv); k++) begin
                flit_done = 1'b1;
                tick();
                flit_done = 1'b0;
                if (k < int'(tbl[v].lv))
                    chk($sformatf("vec%0d.busy%0d", v, k), 32'(busy), 32'd1);
            end
            chk_idle($sformatf("vec%0d.done", v));
        end

        // All requesting, len 0: round-robin rotation (or core always, with priority).
        do_reset();
        req = 5'b11111;
        len = '0;
        for (int t = 0; t < 6; t++) begin
            logic [2:0] exp_code;
`ifdef SCHED_CORE_PRIO_EN
            exp_code = 3'd4;
`else
            exp_code = 3'(t % 5);
`endif
            tick();
            chk_issue($sformatf("rr%0d", t), exp_code);
            ctrl_ready = 1'b1;
            tick();
            ctrl_ready = 1'b0;
            flit_done = 1'b1;
            tick();
            flit_done = 1'b0;
            chk_idle($sformatf("rr%0d.gap", t));
        end
        req = '0;

        // Back-pressure: token held 5 cycles; flit_done during ISSUE ignored.
        do_reset();
        req = 5'b00001;
        len = 15'b011;
        tick();
        req = '0;
        for (int c = 0; c < 5; c++) begin
            chk_issue($sformatf("bp%0d", c), 3'd0);
            flit_done = 1'b1;
            tick();
        end
        flit_done = 1'b0;
        chk_issue("bp_still", 3'd0);
        ctrl_ready = 1'b1;
        tick();
        ctrl_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            flit_done = 1'b1;
            tick();
            flit_done = 1'b0;
            if (k < 3) chk($sformatf("bp_busy%0d", k), 32'(busy), 32'd1);
        end
        chk_idle("bp_done");

        // Reset mid-HOLD abandons packet and zeroes ptr.
        do_reset();
        req = 5'b00010;
        len = {5{3'd2}};
        tick();
        req = '0;
        chk_issue("rst_issue", 3'd1);
        ctrl_ready = 1'b1;
        tick();
        ctrl_ready = 1'b0;
        flit_done = 1'b1;
        tick();
        flit_done = 1'b0;
        chk("rst_hold_busy", 32'(busy), 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        chk_idle("rst_async");
        tick();
        RESET = 1'b0;
        tick();
        tick();
        chk_idle("rst_no_token");
        req = 5'b00110;
        tick();
        req = '0;
        chk_issue("rst_rearb", 3'd1);
        ctrl_ready = 1'b1;
        tick();
        ctrl_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            flit_done = 1'b1;
            tick();
        end
        flit_done = 1'b0;
        chk_idle("rst_rearb_done");

        // req dropped and len changed in HOLD: original length still governs.
        req = 5'b01000;
        len = {5{3'd3}};
        tick();
        chk_issue("late_issue", 3'd3);
        ctrl_ready = 1'b1;
        tick();
        ctrl_ready = 1'b0;
        req = '0;
        len = {5{3'd7}};
        for (int k = 0; k < 4; k++) begin
            flit_done = 1'b1;
            tick();
            flit_done = 1'b0;
            tick();
            if (k < 3) begin
                chk($sformatf("late_busy%0d", k), 32'(busy), 32'd1);
                chk($sformatf("late_grant%0d", k), 32'(grant), 32'h08);
            end
        end
        chk_idle("late_done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
